bsm_pixel_renderer: RTL and testbench

- Consumes the background scanline map (BSM) produced by the GPU front end and serializes it into per-pixel DVI colour for the visible line.
- Each BSM entry is 19 bits: bits [18:16] are the tile colour and bits [15:0] are eight 2-bit pixels.
- The block walks tile columns 0..31 with a one-tile prefetch, shifts out 2 bits per pixel strobe, and maps each pixel value to 2-bit r/g/b.
- It sits between the BSM generate block and the r/g/b output pins. Object compositing is out of scope.

---
 rtl/bsm_pixel_renderer_if.sv | 28 ++
 rtl/bsm_pixel_renderer.sv | 161 ++++++++++++++++
 tb/tb_bsm_pixel_renderer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/bsm_pixel_renderer_if.sv
// Pixel renderer bus: BSM fetch, timing windows, and pixel colour out.
//   master : timing/BSM source side (drives strobes, windows, bsm_entry)
//   slave  : renderer side (drives bsm_col, r/g/b, underrun)
interface bsm_pixel_renderer_if #(
  parameter int TILE_COLS    = 32,
  parameter int PIX_PER_TILE = 8,
  localparam int COL_W = $clog2(TILE_COLS),
  localparam int ENT_W = 2*PIX_PER_TILE + 3
);
  logic             line_start;
  logic             pix_en;
  logic             hvisible;
  logic             vvisible;
  logic [2:0]       backdrop;
  logic [COL_W-1:0] bsm_col;
  logic [ENT_W-1:0] bsm_entry;
  logic [1:0]       r, g, b;
  logic             underrun;

  modport master (
    output line_start, pix_en, hvisible, vvisible, backdrop, bsm_entry,
    input  bsm_col, r, g, b, underrun
  );
  modport slave (
    input  line_start, pix_en, hvisible, vvisible, backdrop, bsm_entry,
    output bsm_col, r, g, b, underrun
  );
endinterface

// File: rtl/bsm_pixel_renderer.sv
// Serializes the background scanline map into per-pixel 2-bit r/g/b.
// Ports:
//   clk  : pixel-domain clock
//   rst  : synchronous active-high reset
//   bus  : slave side of bsm_pixel_renderer_if (timing in, BSM fetch,
//          registered r/g/b and underrun pulse out)
// Tile columns are walked with a one-tile prefetch: shift holds the tile
// on screen, hold holds the next one, reloaded the clk after each boundary.
module bsm_pixel_renderer #(
  parameter int TILE_COLS    = 32,
  parameter int PIX_PER_TILE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  bsm_pixel_renderer_if.slave  bus
);
  localparam int COL_W = $clog2(TILE_COLS);
  localparam int CNT_W = $clog2(PIX_PER_TILE);
  localparam int SH_W  = 2*PIX_PER_TILE;

  typedef enum logic [2:0] {IDLE, PRIME0, PRIME1, READY, RUN} state_t;
  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
  } rgb_t;

  state_t           state, state_nxt;
  logic [SH_W-1:0]  shift, hold;
  logic [2:0]       color, hold_color;
  logic [CNT_W-1:0] pix_cnt;
  logic [COL_W-1:0] col, next_col;
  logic             refill, hvis_q, underrun_q;
  rgb_t             rgb_q;

  logic             visible, vis_strobe, hvis_fall, primed;
  logic             emit, starve, do_prime0, do_prime1, boundary;
  logic [SH_W-1:0]  ent_pix;
  logic [2:0]       ent_color;

  assign ent_pix    = bus.bsm_entry[SH_W-1:0];
  assign ent_color  = bus.bsm_entry[SH_W+2:SH_W];
  assign visible    = bus.hvisible & bus.vvisible;
  assign vis_strobe = bus.pix_en & visible;
  assign hvis_fall  = hvis_q & ~bus.hvisible;

  function automatic rgb_t map_px(input logic [1:0] p, input logic [2:0] tc,
                                  input logic [2:0] bd);
    logic [2:0] c;
    case (p)
      2'b00:   c = bd;
      2'b01:   c = 3'b000;
      2'b10:   c = 3'b111;
      default: c = tc;
    endcase
    return '{r: {2{c[2]}}, g: {2{c[1]}}, b: {2{c[0]}}};
  endfunction

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next state; line_start restarts priming from any state
  always_comb begin
    state_nxt = state;
    if (bus.line_start) state_nxt = PRIME0;
    else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        PRIME0:  state_nxt = PRIME1;
        PRIME1:  state_nxt = READY;
        READY:   if (hvis_fall) state_nxt = IDLE;
                 else if (emit) state_nxt = RUN;
        RUN:     if (hvis_fall) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // per-state datapath strobes
  always_comb begin
    primed    = (state == READY) || (state == RUN);
    emit      = vis_strobe & primed & ~bus.line_start;
    starve    = vis_strobe & ~primed;
    do_prime0 = (state == PRIME0) & ~bus.line_start;
    do_prime1 = (state == PRIME1) & ~bus.line_start;
    boundary  = emit & (pix_cnt == CNT_W'(PIX_PER_TILE-1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift      <= '0;
      hold       <= '0;
      color      <= '0;
      hold_color <= '0;
      pix_cnt    <= '0;
      col        <= '0;
      next_col   <= '0;
      refill     <= 1'b0;
      hvis_q     <= 1'b0;
    end else begin
      hvis_q <= bus.hvisible;
      if (bus.line_start || (primed && hvis_fall)) begin
        // abandon the line: partial tile and pending prefetch are dropped
        col     <= '0;
        pix_cnt <= '0;
        refill  <= 1'b0;
      end else begin
        if (do_prime0) begin
          shift <= ent_pix;
          color <= ent_color;
          col   <= COL_W'(1);
        end
        if (do_prime1) begin
          hold       <= ent_pix;
          hold_color <= ent_color;
          next_col   <= COL_W'(2);
        end
        // bsm_col moved on the boundary clk, so bsm_entry is the new column now
        if (refill) begin
          hold       <= ent_pix;
          hold_color <= ent_color;
          next_col   <= (next_col == COL_W'(TILE_COLS-1)) ? '0 : next_col + COL_W'(1);
          refill     <= 1'b0;
        end
        if (emit) begin
          if (boundary) begin
            shift   <= hold;
            color   <= hold_color;
            col     <= next_col;
            pix_cnt <= '0;
            refill  <= 1'b1;
          end else begin
            shift   <= {shift[SH_W-3:0], 2'b00};
            pix_cnt <= pix_cnt + CNT_W'(1);
          end
        end
      end
    end
  end

  // colour output: blank outside the window, black on starvation, hold otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q      <= '0;
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= starve;
      if (!visible || starve) rgb_q <= '0;
      else if (emit)          rgb_q <= map_px(shift[SH_W-1:SH_W-2], color, bus.backdrop);
    end
  end

  assign bus.bsm_col  = col;
  assign bus.r        = rgb_q.r;
  assign bus.g        = rgb_q.g;
  assign bus.b        = rgb_q.b;
  assign bus.underrun = underrun_q;
endmodule

// File: tb/tb_bsm_pixel_renderer.sv
module tb_bsm_pixel_renderer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bsm_pixel_renderer_if bus();
  bsm_pixel_renderer dut (.clk(clk), .rst(rst), .bus(bus));

  logic [18:0] mem [32];
  always_comb bus.bsm_entry = mem[bus.bsm_col];

  int n_chk = 0, n_err = 0, ucnt = 0;
  always @(posedge clk) if (bus.underrun === 1'b1) ucnt <= ucnt + 1;

  logic [5:0] rgb;
  assign rgb = {bus.r, bus.g, bus.b};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [5:0] px_rgb(input logic [1:0] p, input logic [2:0] tc,
                                        input logic [2:0] bd);
    logic [2:0] c;
    case (p)
      2'b00:   c = bd;
      2'b01:   c = 3'b000;
      2'b10:   c = 3'b111;
      default: c = tc;
    endcase
    return {{2{c[2]}}, {2{c[1]}}, {2{c[0]}}};
  endfunction

  function automatic logic [15:0] pat_of(input int c);
    return 16'(32'h1BE4 ^ c ^ (c << 9) ^ (c << 5));
  endfunction

  function automatic logic [5:0] exp_px(input int i);
    logic [18:0] e;
    int k;
    e = mem[(i / 8) % 32];
    k = i % 8;
    return px_rgb(e[15-2*k -: 2], e[18:16], bus.backdrop);
  endfunction

  // one visible strobe, check the registered pixel, then a gap clk
  task automatic px(input string tag, input logic [5:0] exp);
    bus.pix_en = 1'b1;
    step();
    bus.pix_en = 1'b0;
    chk(tag, rgb, exp);
    step();
  endtask

  task automatic start_line();
    bus.line_start = 1'b1;
    step();
    bus.line_start = 1'b0;
    step(); step(); step();
    bus.hvisible = 1'b1;
    bus.vvisible = 1'b1;
  endtask

  logic [5:0] seq [4];
  int u0;

  initial begin
    seq = '{6'b001100, 6'b000000, 6'b111111, 6'b110000};
    for (int c = 0; c < 32; c++) mem[c] = {3'(c), pat_of(c)};
    bus.line_start = 0; bus.pix_en = 0; bus.hvisible = 0; bus.vvisible = 0;
    bus.backdrop = 3'b010;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("rst_rgb", rgb, 0);
    chk("rst_col", bus.bsm_col, 0);
    chk("rst_urun", bus.underrun, 0);
    step(); step(); step();
    chk("idle_rgb", rgb, 0);
    chk("idle_col", bus.bsm_col, 0);

    // basic tile: 00,01,10,11 pattern twice, then first pixel of col 1
    mem[0] = {3'b100, 16'b00_01_10_11_00_01_10_11};
    mem[1] = {3'b001, 16'hFFFF};
    bus.line_start = 1'b1;
    step();
    bus.line_start = 1'b0;
    chk("prime0_col", bus.bsm_col, 0);
    step();
    chk("prime1_col", bus.bsm_col, 1);
    step(); step();
    bus.hvisible = 1'b1; bus.vvisible = 1'b1;
    for (int k = 0; k < 8; k++) px("basic_px", seq[k % 4]);
    chk("basic_col2", bus.bsm_col, 2);
    px("basic_t1", 6'b000011);
    chk("basic_urun", ucnt, 0);
    bus.hvisible = 1'b0;
    step();
    chk("hfall_rgb", rgb, 0);
    chk("hfall_col", bus.bsm_col, 0);

    // full line, column index drives colour and pattern
    for (int c = 0; c < 32; c++) mem[c] = {3'(c), pat_of(c)};
    bus.backdrop = 3'b101;
    start_line();
    for (int i = 0; i < 256; i++) begin
      px("line_px", exp_px(i));
      if (i == 7)   chk("line_col2", bus.bsm_col, 2);
      if (i == 239) chk("line_col31", bus.bsm_col, 31);
      if (i == 247) chk("line_wrap", bus.bsm_col, 0);
    end
    chk("line_urun", ucnt, 0);
    bus.hvisible = 1'b0;
    step(); step();

    // visible strobes without priming: black and underrun each time
    u0 = ucnt;
    bus.hvisible = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.pix_en = 1'b1;
      step();
      bus.pix_en = 1'b0;
      chk("unp_rgb", rgb, 0);
      chk("unp_urun", bus.underrun, 1);
      step();
    end
    chk("unp_urun_lo", bus.underrun, 0);
    chk("unp_ucnt", ucnt - u0, 4);
    bus.hvisible = 1'b0;
    step(); step();

    // line_start mid-run at pixel 13 restarts from column 0
    start_line();
    for (int i = 0; i < 13; i++) px("ab_px", exp_px(i));
    bus.line_start = 1'b1; bus.pix_en = 1'b1;
    step();
    bus.line_start = 1'b0; bus.pix_en = 1'b0;
    chk("ab_col0", bus.bsm_col, 0);
    chk("ab_hold", rgb, exp_px(12));
    chk("ab_urun", bus.underrun, 0);
    step();
    chk("ab_col1", bus.bsm_col, 1);
    step(); step();
    for (int i = 0; i < 9; i++) begin
      px("re_px", exp_px(i));
      if (i == 7) chk("re_col2", bus.bsm_col, 2);
    end
    bus.vvisible = 1'b0; bus.pix_en = 1'b1;
    step();
    bus.pix_en = 1'b0;
    chk("vblank_rgb", rgb, 0);
    step();
    bus.vvisible = 1'b1;
    px("vis_resume", exp_px(9));

    // reset mid-tile
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_rgb", rgb, 0);
    chk("mrst_col", bus.bsm_col, 0);
    chk("mrst_urun", bus.underrun, 0);
    bus.pix_en = 1'b1;
    step();
    bus.pix_en = 1'b0;
    chk("mrst_need_ls", bus.underrun, 1);
    chk("mrst_blk", rgb, 0);
    step();
    bus.hvisible = 1'b0;
    step();
    start_line();
    px("mrst_px0", exp_px(0));
    px("mrst_px1", exp_px(1));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
